stream_rr_arbiter: RTL and testbench
====================================

// Module: stream_rr_arbiter
//
// PURPOSE
//   Packet-locked round-robin arbiter merging NUM_SRC valid/ready streams onto one
//   downstream stream, e.g. feeding a skid_buffer. A winner keeps the grant until it
//   transfers a beat with last set, or the MAX_BEATS limit forces release. Output is
//   one registered stage tagged with the source index. Full throughput when o_ready=1.
//
// PARAMETERS
//   NUM_SRC     4   number of requesters, >= 1
//   DATA_WIDTH  8   payload bits per beat
//   MAX_BEATS   16  max beats per packet before forced release, >= 1
//   SRC_W       derived: max(1, $clog2(NUM_SRC)); not overridable
//
// PORTS
//   clk          in   1                   rising-edge clock
//   reset_n      in   1                   asynchronous, active-low reset
//   i_valid      in   NUM_SRC             per-source beat valid
//   i_ready      out  NUM_SRC             per-source beat accept
//   i_data       in   NUM_SRC*DATA_WIDTH  source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_last       in   NUM_SRC             per-source end-of-packet flag
//   o_valid      out  1                   output beat valid
//   o_ready      in   1                   downstream accept
//   o_data       out  DATA_WIDTH          output payload
//   o_last       out  1                   end of packet (incl. forced)
//   o_src        out  SRC_W               source index of current output beat
//   o_busy       out  1                   1 while in LOCKED
//   err_overrun  out  1                   sticky: a packet hit MAX_BEATS without last
//   err_clear    in   1                   synchronous clear of err_overrun
//
// BEHAVIOUR
//   - Reset (reset_n=0, async): state=IDLE, rr_ptr=0, beat_cnt=0, o_valid=0, o_data=0,
//     o_last=0, o_src=0, err_overrun=0; i_ready=0 (reset_n gates it combinationally).
//   - space = !o_valid || o_ready. A beat from k transfers when i_valid[k] && i_ready[k].
//   - States: IDLE (no owner), LOCKED (owner register holds the source index).
//   - IDLE: pick = first k with i_valid[k], searching rr_ptr, rr_ptr+1, ... mod NUM_SRC.
//     i_ready[pick] = space; all other i_ready = 0; no valid -> all i_ready = 0.
//   - LOCKED: i_ready[owner] = space; all others 0. Other requests are ignored.
//     Owner dropping i_valid mid-packet keeps the lock; no timeout.
//   - i_ready may depend on i_valid and o_ready combinationally. Never on i_data.
//   - Transfer updates at the next edge:
//     o_valid=1; o_data=i_data[k]; o_src=k; o_last=i_last[k] || (beat_cnt+1==MAX_BEATS).
//     If the beat is last (incl. forced): state=IDLE, rr_ptr=(k+1) mod NUM_SRC, beat_cnt=0.
//     Otherwise: state=LOCKED, owner=k, beat_cnt+=1.
//   - Forced release (beat_cnt+1==MAX_BEATS && !i_last[k]): err_overrun<=1.
//     Set wins over a simultaneous err_clear. The rest of that packet arbitrates as a new packet.
//   - No transfer && o_ready: o_valid<=0. o_valid && !o_ready: o_* hold stable.
//   - Latency: 1 cycle from input transfer to o_valid. Back-to-back beats with no bubbles,
//     including across packet boundaries and source switches.
//   - MAX_BEATS=1: every beat is a packet; rr rotates each beat; err on any beat without last.
//   - NUM_SRC=1: rr_ptr stays 0; o_src=0; block acts as a pipeline reg plus packet counter.
//   - Reset asserted mid-packet: everything returns to reset values immediately.
//     A partial packet is dropped with no last emitted.
//
// TESTING
//   1 All 4 sources valid, 1-beat packets, o_ready=1 -> o_src 0,1,2,3,0; one beat/cycle; o_valid 1 cycle after first i_valid.
//   2 Src1 sends 3 beats (last on 3rd) while src2 valid throughout -> o_src 1,1,1,2; i_ready[2]=0 until src1 last transfers.
//   3 o_ready=0 for 4 cycles holding a beat -> o_data/o_last/o_src stable; all i_ready=0; resume -> no loss or duplication.
//   4 MAX_BEATS=16, src0 streams 20 beats with no last -> beat 16 has o_last=1, err_overrun=1; err_clear -> 0; simultaneous set+clear -> stays 1.
//   5 Src3 drops i_valid for 5 cycles mid-packet with src0 valid -> no src0 beats; o_busy=1 until src3 last.
//   6 reset_n pulsed low mid-packet (async, off-edge) -> o_valid, o_busy, i_ready go 0 immediately; next grant starts at src0.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
//   Packet-locked round-robin arbiter. It merges NUM_SRC valid/ready beat streams
//   onto one registered downstream stream. Each output beat is tagged with the
//   index of the source that sent it.
//
//   A source that wins arbitration owns the output until one of two things happens:
//     - it transfers a beat with last set, or
//     - its packet reaches MAX_BEATS beats. The block then emits a forced last and
//       sets the sticky err_overrun flag.
//   When ownership is released, the round-robin pointer moves to the source just
//   after the previous owner.
//
//   The output is a single register stage, so the block gives one beat per cycle
//   while o_ready stays high.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset (also gates i_ready to 0)
//   i_valid      per-source beat valid
//   i_ready      per-source beat accept
//   i_data       packed payloads, source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_last       per-source end-of-packet flag
//   o_valid      output beat valid
//   o_ready      downstream accept
//   o_data       output payload
//   o_last       end of packet (includes forced release)
//   o_src        source index of the current output beat
//   o_busy       high while a source owns the output mid-packet
//   err_overrun  sticky: a packet hit MAX_BEATS without last
//   err_clear    synchronous clear of err_overrun (a simultaneous set wins)
module stream_rr_arbiter #(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BEATS  = 16,
  localparam int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_SRC-1:0]            i_valid,
  output logic [NUM_SRC-1:0]            i_ready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_SRC-1:0]            i_last,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_last,
  output logic [SRC_W-1:0]              o_src,
  output logic                          o_busy,
  output logic                          err_overrun,
  input  logic                          err_clear
);

  // beat_cnt counts the beats already sent in the open packet: 0 .. MAX_BEATS-1
  localparam int                CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_BEATS - 1);
  localparam logic [SRC_W-1:0]  SRC_MAX   = SRC_W'(NUM_SRC - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Source index + 1, wrapping at NUM_SRC (NUM_SRC need not be a power of two)
  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] s);
    return (s == SRC_MAX) ? '0 : s + 1'b1;
  endfunction

  // First valid source at or after ptr, in circular order.
  // Returned as {found, index}.
  function automatic logic [SRC_W:0] rr_pick(input logic [SRC_W-1:0]   ptr,
                                             input logic [NUM_SRC-1:0] req);
    logic [SRC_W-1:0] cand;
    logic [SRC_W-1:0] pick;
    logic             found;
    cand  = ptr;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
      cand = wrap_inc(cand);
    end
    return {found, pick};
  endfunction

  state_t                  state;
  logic [SRC_W-1:0]        owner;
  logic [SRC_W-1:0]        rr_ptr;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    err_q;

  logic                    vld_p0;
  logic [DATA_WIDTH-1:0]   data_p0;
  logic                    last_p0;
  logic [SRC_W-1:0]        src_p0;

  logic [DATA_WIDTH-1:0]   src_data [NUM_SRC];
  logic [SRC_W:0]          pick_res;
  logic [SRC_W-1:0]        sel;
  logic                    grant_en;
  logic                    space;
  logic                    xfer;
  logic                    at_limit;
  logic                    beat_last;
  logic                    forced;

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      src_data[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Input side: grant selection (combinational, never depends on i_data)
  always_comb begin
    space    = !vld_p0 || o_ready;
    pick_res = rr_pick(rr_ptr, i_valid);
    if (state == LOCKED) begin
      // The owner keeps the grant even while its i_valid is low
      sel      = owner;
      grant_en = 1'b1;
    end else begin
      sel      = pick_res[SRC_W-1:0];
      grant_en = pick_res[SRC_W];
    end

    i_ready = '0;
    if (reset_n && grant_en && space) begin
      i_ready[sel] = 1'b1;
    end

    xfer      = reset_n && grant_en && space && i_valid[sel];
    at_limit  = (beat_cnt == CNT_LIMIT);
    beat_last = i_last[sel] || at_limit;
    forced    = at_limit && !i_last[sel];
  end

  // Output register stage p0 plus arbitration state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      vld_p0   <= 1'b0;
      data_p0  <= '0;
      last_p0  <= 1'b0;
      src_p0   <= '0;
    end else begin
      if (xfer) begin
        vld_p0  <= 1'b1;
        data_p0 <= src_data[sel];
        src_p0  <= sel;
        last_p0 <= beat_last;
        if (beat_last) begin
          state    <= IDLE;
          rr_ptr   <= wrap_inc(sel);
          beat_cnt <= '0;
        end else begin
          state    <= LOCKED;
          owner    <= sel;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end else if (o_ready) begin
        vld_p0 <= 1'b0;
      end

      if (xfer && forced) begin
        err_q <= 1'b1;
      end else if (err_clear) begin
        err_q <= 1'b0;
      end
    end
  end

  assign o_valid     = vld_p0;
  assign o_data      = data_p0;
  assign o_last      = last_p0;
  assign o_src       = src_p0;
  assign o_busy      = (state == LOCKED);
  assign err_overrun = err_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
module tb_stream_rr_arbiter;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic              clk;
  logic              reset_n;
  logic [NS-1:0]     i_valid;
  logic [NS-1:0]     i_ready;
  logic [NS*DW-1:0]  i_data;
  logic [NS-1:0]     i_last;
  logic              o_valid;
  logic              o_ready;
  logic [DW-1:0]     o_data;
  logic              o_last;
  logic [1:0]        o_src;
  logic              o_busy;
  logic              err_overrun;
  logic              err_clear;

  stream_rr_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_data      (i_data),
    .i_last      (i_last),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_last      (o_last),
    .o_src       (o_src),
    .o_busy      (o_busy),
    .err_overrun (err_overrun),
    .err_clear   (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: owner (-1 = nobody), pointer, beats sent, expected outputs
  int          m_owner;
  int          m_ptr;
  int          m_cnt;
  logic        m_err;
  logic        e_valid;
  logic [DW-1:0] e_data;
  logic        e_last;
  int          e_src;
  int          obs_src[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_err   = 1'b0;
    e_valid = 1'b0;
    e_data  = '0;
    e_last  = 1'b0;
    e_src   = 0;
  endtask

  function automatic logic [NS-1:0] model_ready();
    logic [NS-1:0] r;
    logic          sp;
    r  = '0;
    sp = !e_valid || o_ready;
    if (m_owner >= 0) begin
      r[m_owner] = sp;
    end else begin
      for (int j = NS - 1; j >= 0; j--) begin
        int c;
        c = (m_ptr + j) % NS;
        if (i_valid[c]) r = '0;
        if (i_valid[c]) r[c] = sp;
      end
    end
    return r;
  endfunction

  task automatic drive(input logic [NS-1:0] v, input logic [NS-1:0] l,
                       input logic rdy, input logic clr);
    i_valid   = v;
    i_last    = l;
    o_ready   = rdy;
    err_clear = clr;
    i_data    = {$urandom, $urandom} [NS*DW-1:0];
  endtask

  // One clock: check grants before the edge, advance the model, check outputs after
  task automatic cycle();
    logic [NS-1:0] er;
    int            k;
    logic          lim;
    logic          lst;
    #1;
    er = model_ready();
    chk("i_ready", 32'(i_ready), 32'(er));
    k = -1;
    for (int j = 0; j < NS; j++) if (i_valid[j] && er[j]) k = j;
    @(posedge clk);
    #1;
    if (k >= 0) begin
      lim = (m_cnt + 1 == MB);
      lst = i_last[k] || lim;
      if (lim && !i_last[k]) m_err = 1'b1;
      else if (err_clear)    m_err = 1'b0;
      e_valid = 1'b1;
      e_data  = i_data[k*DW +: DW];
      e_src   = k;
      e_last  = lst;
      if (lst) begin
        m_owner = -1;
        m_ptr   = (k + 1) % NS;
        m_cnt   = 0;
      end else begin
        m_owner = k;
        m_cnt++;
      end
      obs_src.push_back(int'(o_src));
    end else begin
      if (err_clear) m_err = 1'b0;
      if (o_ready)   e_valid = 1'b0;
    end
    chk("o_valid", 32'(o_valid), 32'(e_valid));
    chk("o_data", 32'(o_data), 32'(e_data));
    chk("o_last", 32'(o_last), 32'(e_last));
    chk("o_src", 32'(o_src), 32'(e_src));
    chk("o_busy", 32'(o_busy), 32'(m_owner >= 0));
    chk("err_overrun", 32'(err_overrun), 32'(m_err));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seq1[5];
    int seq2[4];
    seq1 = '{0, 1, 2, 3, 0};
    seq2 = '{1, 1, 1, 2};

    reset_n = 1'b0;
    drive(4'hF, 4'hF, 1'b1, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_o_last", 32'(o_last), 32'd0);
    chk("rst_o_src", 32'(o_src), 32'd0);
    chk("rst_o_busy", 32'(o_busy), 32'd0);
    chk("rst_err", 32'(err_overrun), 32'd0);
    chk("rst_i_ready", 32'(i_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: all sources with 1-beat packets rotate
    obs_src.delete();
    for (int i = 0; i < 5; i++) begin
      drive(4'hF, 4'hF, 1'b1, 1'b0);
      cycle();
    end
    drive(4'h0, 4'h0, 1'b1, 1'b0);
    cycle();
    chk("t1_count", 32'(obs_src.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs_src.size(); i++)
      chk("t1_src_seq", 32'(obs_src[i]), 32'(seq1[i]));

    // 2: src1 3-beat packet, src2 waits
    obs_src.delete();
    drive(4'b0110, 4'b0100, 1'b1, 1'b0); cycle();
    drive(4'b0110, 4'b0100, 1'b1, 1'b0); cycle();
    drive(4'b0110, 4'b0110, 1'b1, 1'b0); cycle();
    drive(4'b0100, 4'b0100, 1'b1, 1'b0); cycle();
    drive(4'b0000, 4'b0000, 1'b1, 1'b0); cycle();
    chk("t2_count", 32'(obs_src.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_src.size(); i++)
      chk("t2_src_seq", 32'(obs_src[i]), 32'(seq2[i]));

    // 3: downstream stall holds the output beat
    drive(4'b0001, 4'b0001, 1'b1, 1'b0); cycle();
    for (int i = 0; i < 4; i++) begin
      drive(4'b0001, 4'b0001, 1'b0, 1'b0);
      cycle();
      chk("t3_stall_ready", 32'(i_ready), 32'd0);
    end
    drive(4'b0001, 4'b0001, 1'b1, 1'b0); cycle();
    drive(4'b0000, 4'b0000, 1'b1, 1'b0); cycle();

    // 4: overrun forces last at beat MB, then clear, then set beats clear
    for (int i = 0; i < 20; i++) begin
      drive(4'b0001, 4'b0000, 1'b1, 1'b0);
      cycle();
      if (i == MB - 1) begin
        chk("t4_forced_last", 32'(o_last), 32'd1);
        chk("t4_err_set", 32'(err_overrun), 32'd1);
      end
    end
    drive(4'b0001, 4'b0001, 1'b1, 1'b0); cycle();
    drive(4'b0000, 4'b0000, 1'b1, 1'b1); cycle();
    chk("t4_err_cleared", 32'(err_overrun), 32'd0);
    for (int i = 0; i < MB; i++) begin
      drive(4'b0001, 4'b0000, 1'b1, 1'b1);
      cycle();
    end
    chk("t4_set_wins", 32'(err_overrun), 32'd1);
    drive(4'b0000, 4'b0000, 1'b1, 1'b1); cycle();

    // 5: owner src3 idles mid-packet, src0 is ignored
    drive(4'b1000, 4'b0000, 1'b1, 1'b0); cycle();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, 4'b0001, 1'b1, 1'b0);
      cycle();
      chk("t5_busy", 32'(o_busy), 32'd1);
    end
    drive(4'b1001, 4'b1001, 1'b1, 1'b0); cycle();
    drive(4'b0001, 4'b0001, 1'b1, 1'b0); cycle();
    chk("t5_src0_after", 32'(o_src), 32'd0);

    // 6: asynchronous reset mid-packet
    drive(4'b0100, 4'b0000, 1'b1, 1'b0); cycle();
    drive(4'b0100, 4'b0000, 1'b1, 1'b0); cycle();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_o_valid", 32'(o_valid), 32'd0);
    chk("t6_o_busy", 32'(o_busy), 32'd0);
    chk("t6_i_ready", 32'(i_ready), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    drive(4'hF, 4'hF, 1'b1, 1'b0); cycle();
    chk("t6_first_src", 32'(o_src), 32'd0);

    // Random traffic: short packets, then long ones that reach the limit
    for (int i = 0; i < 400; i++) begin
      logic [NS-1:0] v, l;
      v = NS'($urandom);
      if (i < 200) l = NS'($urandom & $urandom);
      else         l = NS'($urandom & $urandom & $urandom & $urandom & $urandom);
      drive(v, l, ($urandom % 4) != 0, ($urandom % 16) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
